// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// -----------------------------------------------------------------------------
// Pipeline hazard controller for the 5-stage RV32 core. It sequences the PC,
// IF/ID, ID/EX and EX stage enables around three events, listed here in
// priority order:
//   1. a taken branch or jump resolved in EX,
//   2. a multi-cycle EX op (mul/div),
//   3. a load-use hazard.
// Operand forwarding is a separate unit. This block only produces the stalls
// and bubbles that forwarding cannot cover.
//
// Optional feature, enabled by defining the macro STALL_PERF_CNT_EN:
//   stall_cnt counts the cycles with rst=0 and pcWrite=0. It saturates at
//   all-ones and is cleared by rst. With the macro undefined, stall_cnt is
//   tied to 0 and no counter flops are built.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   id_Rs1/id_Rs2  source registers of the instruction in ID
//   ex_Rd          destination register of the instruction in EX
//   ex_memRead     the EX instruction is a load
//   ex_mcOp        EX holds a multi-cycle op (level; stays high while in EX)
//   ex_branchTaken the branch/jump in EX resolved taken
//   pcWrite        PC update enable
//   ifidWrite      IF/ID register enable
//   ifidFlush      zero IF/ID (insert NOP)
//   idexFlush      zero ID/EX control (bubble)
//   exHold         freeze ID/EX and the EX unit; EX/MEM receives a bubble
//   mc_busy        high while waiting out a multi-cycle op (MC_WAIT)
//   stall_cnt      stall-cycle count (0 unless STALL_PERF_CNT_EN)
//
// Handshake / timing: there is no valid/ready traffic. All outputs are
// combinational from the registered state and the current inputs. The only
// registered values are the FSM state, the multi-cycle down-counter and,
// when enabled, the performance counter. The internal signal 'state' holds
// the FSM state for debug probing.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int MC_LATENCY       = 4,
  parameter int CNT_BITWIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs2,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_Rd,
  input  logic                        ex_memRead,
  input  logic                        ex_mcOp,
  input  logic                        ex_branchTaken,
  output logic                        pcWrite,
  output logic                        ifidWrite,
  output logic                        ifidFlush,
  output logic                        idexFlush,
  output logic                        exHold,
  output logic                        mc_busy,
  output logic [CNT_BITWIDTH-1:0]     stall_cnt
);

  // The down-counter only ever holds values in the range 0..MC_LATENCY-1.
  localparam int CW = (MC_LATENCY < 1) ? 1 : $clog2(MC_LATENCY + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    MC_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          luse;

  // A load in EX writes a register that the instruction in ID reads.
  // x0 never creates a dependency.
  assign luse = ex_memRead && (ex_Rd != '0) &&
                ((ex_Rd == id_Rs1) || (ex_Rd == id_Rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pcWrite   = 1'b1;
    ifidWrite = 1'b1;
    ifidFlush = 1'b0;
    idexFlush = 1'b0;
    exHold    = 1'b0;
    mc_busy   = 1'b0;

    if (rst) begin
      // Fill the front of the pipe with NOPs while reset is held.
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_branchTaken) begin
            // Squash the two wrong-path instructions. The PC loads the target.
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
          end else if (ex_mcOp) begin
            // This is the first hold cycle. The remaining MC_LATENCY-1 cycles
            // are spent in MC_WAIT.
            exHold    = 1'b1;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            if (MC_LATENCY == 1) begin
              state_nxt = MC_DONE;
            end else begin
              cnt_nxt   = CW'(MC_LATENCY - 1);
              state_nxt = MC_WAIT;
            end
          end else if (luse) begin
            // Single bubble. Once the load reaches MEM, forwarding covers it.
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
          end
        end

        MC_WAIT: begin
          exHold    = 1'b1;
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          mc_busy   = 1'b1;
          if (cnt == CW'(1)) begin
            cnt_nxt   = '0;
            state_nxt = MC_DONE;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end

        MC_DONE: begin
          // ex_mcOp is still high here, but it belongs to the op that is
          // releasing this cycle, so it must not restart the sequence.
          state_nxt = RUN;
          if (ex_branchTaken) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
          end else if (luse) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
          end
        end

        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_BITWIDTH-1:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (!pcWrite && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + CNT_BITWIDTH'(1);
    end
  end

  assign stall_cnt = perf_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl.
// Main instance: MC_LATENCY=4, CNT_BITWIDTH=16. It is checked by directed
// scenarios and by randomized traffic against a cycle-position reference model.
// Second instance: MC_LATENCY=1, CNT_BITWIDTH=2. It covers the single-hold
// case and counter saturation.
// Output vector order: {pcWrite, ifidWrite, ifidFlush, idexFlush, exHold, mc_busy}
module tb_hazard_stall_ctrl;
  localparam int RW  = 5;
  localparam int LAT = 4;
  localparam int CB  = 16;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] O_RST  = 6'b001100;
  localparam logic [5:0] O_IDLE = 6'b110000;
  localparam logic [5:0] O_LUSE = 6'b000100;
  localparam logic [5:0] O_BR   = 6'b111100;
  localparam logic [5:0] O_HOLD = 6'b000010;
  localparam logic [5:0] O_BUSY = 6'b000011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [RW-1:0] id_Rs1 = '0, id_Rs2 = '0, ex_Rd = '0;
  logic          ex_memRead = 1'b0, ex_mcOp = 1'b0, ex_branchTaken = 1'b0;
  logic          pcWrite, ifidWrite, ifidFlush, idexFlush, exHold, mc_busy;
  logic [CB-1:0] stall_cnt;
  logic [5:0]    obs;
  assign obs = {pcWrite, ifidWrite, ifidFlush, idexFlush, exHold, mc_busy};

  logic          s_rst = 1'b1;
  logic [RW-1:0] s_Rs1 = '0, s_Rs2 = '0, s_Rd = '0;
  logic          s_memRead = 1'b0, s_mcOp = 1'b0, s_br = 1'b0;
  logic          s_pcWrite, s_ifidWrite, s_ifidFlush, s_idexFlush, s_exHold, s_mc_busy;
  logic [1:0]    s_stall_cnt;
  logic [5:0]    s_obs;
  assign s_obs = {s_pcWrite, s_ifidWrite, s_ifidFlush, s_idexFlush, s_exHold, s_mc_busy};

  hazard_stall_ctrl #(.REG_NUM_BITWIDTH(RW), .MC_LATENCY(LAT), .CNT_BITWIDTH(CB)) u_dut (
    .clk(clk), .rst(rst), .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .ex_Rd(ex_Rd),
    .ex_memRead(ex_memRead), .ex_mcOp(ex_mcOp), .ex_branchTaken(ex_branchTaken),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexFlush(idexFlush), .exHold(exHold), .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.REG_NUM_BITWIDTH(RW), .MC_LATENCY(1), .CNT_BITWIDTH(2)) u_dut1 (
    .clk(clk), .rst(s_rst), .id_Rs1(s_Rs1), .id_Rs2(s_Rs2), .ex_Rd(s_Rd),
    .ex_memRead(s_memRead), .ex_mcOp(s_mcOp), .ex_branchTaken(s_br),
    .pcWrite(s_pcWrite), .ifidWrite(s_ifidWrite), .ifidFlush(s_ifidFlush),
    .idexFlush(s_idexFlush), .exHold(s_exHold), .mc_busy(s_mc_busy), .stall_cnt(s_stall_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // m_pos is the position of the upcoming cycle within a multi-cycle op:
  // 0 = no op in progress, 1..LAT = hold cycles, LAT+1 = release cycle.
  int     m_pos = 0;
  longint m_cnt = 0;

  function automatic bit m_luse();
    return ex_memRead && (ex_Rd != 0) && (ex_Rd == id_Rs1 || ex_Rd == id_Rs2);
  endfunction

  function automatic int m_cur_pos();
    if (m_pos == 0 && !ex_branchTaken && ex_mcOp) return 1;
    return m_pos;
  endfunction

  function automatic logic [5:0] m_out();
    int p;
    if (rst) return O_RST;
    p = m_cur_pos();
    if (p >= 1 && p <= LAT) return (p >= 2) ? O_BUSY : O_HOLD;
    if (ex_branchTaken) return O_BR;
    if (m_luse()) return O_LUSE;
    return O_IDLE;
  endfunction

  function automatic logic [CB-1:0] m_stall();
    return PERF ? CB'(m_cnt) : '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rd, input logic mr, input logic mc, input logic br);
    rst = r; id_Rs1 = rs1; id_Rs2 = rs2; ex_Rd = rd;
    ex_memRead = mr; ex_mcOp = mc; ex_branchTaken = br;
    #3;
  endtask

  // Step the model over the current cycle, then move to the next cycle.
  task automatic advance();
    logic [5:0] e;
    int p;
    e = m_out();
    if (rst) begin
      m_pos = 0;
      m_cnt = 0;
    end else begin
      p = m_cur_pos();
      m_pos = (p >= 1 && p <= LAT) ? p + 1 : 0;
      if (!e[5] && m_cnt < (longint'(1) << CB) - 1) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (obs !== O_RST) begin
        miscompares++;
        $display("FAIL reset_outs: got %b expected %b", obs, O_RST);
      end
      advance();
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b expected %b", obs, O_IDLE);
    end
    vectors++;
    if (stall_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [5:0] exp_tab [4];
    exp_tab[0] = O_LUSE;  // rs1 matches
    exp_tab[1] = O_IDLE;  // rd = x0
    exp_tab[2] = O_LUSE;  // rs2 matches
    exp_tab[3] = O_IDLE;  // not a load
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1'b0, 5, 7, 5, 1, 0, 0);
        1: drive(1'b0, 0, 7, 0, 1, 0, 0);
        2: drive(1'b0, 3, 9, 9, 1, 0, 0);
        default: drive(1'b0, 5, 7, 5, 0, 0, 0);
      endcase
      vectors++;
      if (obs !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL load_use_%0d: got %b expected %b", i, obs, exp_tab[i]);
      end
      advance();
    end
  endtask

  task automatic test_branch_priority();
    drive(1'b0, 5, 7, 5, 1, 0, 1);  // branch + load-use
    vectors++;
    if (obs !== O_BR) begin
      miscompares++;
      $display("FAIL branch_over_luse: got %b expected %b", obs, O_BR);
    end
    advance();
    drive(1'b0, 0, 0, 0, 0, 1, 1);  // branch + mc op: the op is squashed
    vectors++;
    if (obs !== O_BR) begin
      miscompares++;
      $display("FAIL branch_over_mc: got %b expected %b", obs, O_BR);
    end
    advance();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL no_hold_after_branch: got %b expected %b", obs, O_IDLE);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    int p;
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    advance();
    drive(1'b0, 5, 7, 5, 1, 0, 0);  // one load-use stall
    advance();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 0, 0, 0, 0, 1, 0);
      p = (k - 1) % 5 + 1;
      e = (p == 1) ? O_HOLD : (p == 5) ? O_IDLE : O_BUSY;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL mc_cycle_%0d: got %b expected %b", k, obs, e);
      end
      if (k == 5 || k == 10) begin
        vectors++;
        if (stall_cnt !== (PERF ? CB'(k == 5 ? 5 : 9) : CB'(0))) begin
          miscompares++;
          $display("FAIL stall_cnt_cycle_%0d: got %0d expected %0d", k, stall_cnt,
                   PERF ? (k == 5 ? 5 : 9) : 0);
        end
      end
      advance();
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== O_IDLE) begin
      miscompares++;
      $display("FAIL after_b2b: got %b expected %b", obs, O_IDLE);
    end
    advance();
  endtask

  task automatic test_reset_in_mc();
    drive(1'b0, 0, 0, 0, 0, 1, 0);
    advance();
    drive(1'b1, 0, 0, 0, 0, 1, 0);  // reset during MC_WAIT cycle 2
    vectors++;
    if (obs !== O_RST) begin
      miscompares++;
      $display("FAIL reset_in_wait: got %b expected %b", obs, O_RST);
    end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (obs !== O_IDLE) begin
        miscompares++;
        $display("FAIL no_residual_hold_%0d: got %b expected %b", i, obs, O_IDLE);
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [5:0]    e;
    logic [CB-1:0] ec;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0,
            RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      e  = m_out();
      ec = m_stall();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL random_outs_%0d: got %b expected %b", i, obs, e);
      end
      vectors++;
      if (stall_cnt !== ec) begin
        miscompares++;
        $display("FAIL random_stall_cnt_%0d: got %0d expected %0d", i, stall_cnt, ec);
      end
      advance();
    end
  endtask

  // MC_LATENCY=1 instance: one hold cycle with no busy, then saturation of the
  // 2-bit counter.
  task automatic test_lat1_saturate();
    logic [5:0] exp_tab [3];
    exp_tab[0] = O_HOLD;
    exp_tab[1] = O_IDLE;
    exp_tab[2] = O_IDLE;
    s_rst = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    advance();
    s_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_mcOp = (i < 2);
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (s_obs !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL lat1_cycle_%0d: got %b expected %b", i, s_obs, exp_tab[i]);
      end
      advance();
    end
    vectors++;
    if (s_stall_cnt !== (PERF ? 2'd1 : 2'd0)) begin
      miscompares++;
      $display("FAIL lat1_stall_cnt: got %0d expected %0d", s_stall_cnt, PERF ? 1 : 0);
    end
    s_memRead = 1'b1; s_Rd = 5'd4; s_Rs1 = 5'd4; s_Rs2 = 5'd1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (s_obs !== O_LUSE) begin
        miscompares++;
        $display("FAIL sat_luse_%0d: got %b expected %b", i, s_obs, O_LUSE);
      end
      advance();
    end
    s_memRead = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (s_stall_cnt !== (PERF ? 2'd3 : 2'd0)) begin
      miscompares++;
      $display("FAIL sat_stall_cnt: got %0d expected %0d", s_stall_cnt, PERF ? 3 : 0);
    end
    advance();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_back_to_back();
    test_reset_in_mc();
    test_random();
    test_lat1_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
